tx_arbiter: RTL and testbench

Owns the serial TX pins and shares them between the two requesters that issue bus commands: the instruction scheduler (memory reads, writes, PC-write prefetch) and the instruction prefetcher (sequential 16-bit reads). It arbitrates, latches the winning command, serializes header plus payload at NSHIFT bits per cycle, and drives the per-cycle payload handshake back to the owner. It also tracks outstanding read replies so that the RX side never receives more replies than it can steer.

---
 rtl/tx_arbiter_pkg.sv | 36 +++
 rtl/tx_arbiter_if.sv | 42 ++++
 rtl/tx_arbiter_read_credit_counter.sv | 28 ++
 rtl/tx_arbiter.sv | 133 +++++++++++++
 tb/tb_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared TX command codes, arbiter state type and small helpers.
// Command macros are guarded so another shared header can define them first.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 2
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 2'd1
`endif
`ifndef TX_HEADER_WRITE_8
`define TX_HEADER_WRITE_8 2'd2
`endif
`ifndef TX_HEADER_WRITE_16
`define TX_HEADER_WRITE_16 2'd3
`endif

package tx_arbiter_pkg;

  localparam int CMD_BITS = `TX_CMD_BITS;

  typedef logic [CMD_BITS-1:0] tx_cmd_t;

  localparam tx_cmd_t CMD_READ_16  = `TX_HEADER_READ_16;
  localparam tx_cmd_t CMD_WRITE_8  = `TX_HEADER_WRITE_8;
  localparam tx_cmd_t CMD_WRITE_16 = `TX_HEADER_WRITE_16;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } tx_state_t;

  function automatic logic is_read(input tx_cmd_t cmd);
    return cmd == CMD_READ_16;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester-side bundle of the TX arbiter: scheduler and prefetch handshakes,
// RX reply notification and the serial/status outputs.
interface tx_arbiter_if #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int MAX_READS      = 2
);
  import tx_arbiter_pkg::*;

  logic                               sched_cmd_valid;
  tx_cmd_t                            sched_cmd;
  logic                               sched_reserve;
  logic                               sched_reply_wanted;
  logic [NSHIFT-1:0]                  sched_data;
  logic                               sched_cmd_started;
  logic                               pf_cmd_valid;
  logic [NSHIFT-1:0]                  pf_data;
  logic                               pf_cmd_started;
  logic                               rx_reply_done;
  logic                               tx_active;
  logic                               tx_owner_sched;
  logic                               tx_data_next;
  logic [$clog2(PAYLOAD_CYCLES):0]    tx_counter;
  logic                               tx_done;
  logic [NSHIFT-1:0]                  tx_pins;
  logic [$clog2(MAX_READS+1)-1:0]     reads_outstanding;

  modport master (
    output sched_cmd_valid, sched_cmd, sched_reserve, sched_reply_wanted, sched_data,
    output pf_cmd_valid, pf_data, rx_reply_done,
    input  sched_cmd_started, pf_cmd_started, tx_active, tx_owner_sched,
    input  tx_data_next, tx_counter, tx_done, tx_pins, reads_outstanding
  );

  modport slave (
    input  sched_cmd_valid, sched_cmd, sched_reserve, sched_reply_wanted, sched_data,
    input  pf_cmd_valid, pf_data, rx_reply_done,
    output sched_cmd_started, pf_cmd_started, tx_active, tx_owner_sched,
    output tx_data_next, tx_counter, tx_done, tx_pins, reads_outstanding
  );

endinterface

// File: rtl/tx_arbiter_read_credit_counter.sv
// Saturating count of read replies still owed by the RX side; can_read says
// another counted read may be issued.
module read_credit_counter #(
  parameter int MAX_READS = 2,
  parameter int RD_W      = $clog2(MAX_READS+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [RD_W-1:0] count,
  output logic            can_read
);

  assign can_read = count < RD_W'(MAX_READS);

  // Simultaneous issue and reply cancel out; a stray reply at zero is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && can_read) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the serial TX pins between the scheduler and the prefetcher, serializes
// header + payload and tracks outstanding reads. Optional: TX_ARB_ROUND_ROBIN_EN.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int MAX_READS      = 2
) (
  input  logic clk,
  input  logic reset,
  tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;
  localparam int RD_W  = $clog2(MAX_READS + 1);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(PAYLOAD_CYCLES / 2 - 1);

  tx_state_t        state, state_next;
  logic             owner_sched;
  tx_cmd_t          cmd_q;
  logic [CNT_W-1:0] counter_q;
  logic             sched_started_q, pf_started_q;
  logic             can_read;
  logic [RD_W-1:0]  reads;
  logic             tx_done, arb_en, sched_elig, pf_elig;
  logic             grant_sched, grant_pf, grant, grant_counted;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic favour_pf;
`endif

  read_credit_counter #(.MAX_READS(MAX_READS), .RD_W(RD_W)) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_counted),
    .dec      (bus.rx_reply_done),
    .count    (reads),
    .can_read (can_read)
  );

  // Arbitration is open when idle and in the last payload cycle so frames can abut.
  always_comb begin
    tx_done     = (state == PAYLOAD) &&
                  (counter_q == ((cmd_q == CMD_WRITE_8) ? LAST_HALF : LAST_FULL));
    arb_en      = (state == IDLE) || tx_done;
    sched_elig  = bus.sched_cmd_valid &&
                  (!is_read(bus.sched_cmd) || !bus.sched_reply_wanted || can_read);
    pf_elig     = bus.pf_cmd_valid && can_read && !bus.sched_reserve;
    grant_sched = 1'b0;
    grant_pf    = 1'b0;
    if (arb_en) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      if (sched_elig && pf_elig) begin
        grant_pf    = favour_pf;
        grant_sched = !favour_pf;
      end else begin
        grant_sched = sched_elig;
        grant_pf    = pf_elig;
      end
`else
      grant_sched = sched_elig;
      grant_pf    = pf_elig && !sched_elig;
`endif
    end
    grant         = grant_sched || grant_pf;
    grant_counted = grant_pf ||
                    (grant_sched && is_read(bus.sched_cmd) && bus.sched_reply_wanted);

    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = HEADER;
      HEADER:  state_next = PAYLOAD;
      PAYLOAD: if (tx_done) state_next = grant ? HEADER : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      owner_sched     <= 1'b0;
      cmd_q           <= '0;
      counter_q       <= '0;
      sched_started_q <= 1'b0;
      pf_started_q    <= 1'b0;
    end else begin
      state           <= state_next;
      sched_started_q <= grant_sched;
      pf_started_q    <= grant_pf;
      if (grant) begin
        owner_sched <= grant_sched;
        cmd_q       <= grant_sched ? bus.sched_cmd : CMD_READ_16;
      end
      if (state == PAYLOAD && !tx_done) begin
        counter_q <= counter_q + 1'b1;
      end else begin
        counter_q <= '0;
      end
    end
  end

`ifdef TX_ARB_ROUND_ROBIN_EN
  // Only contested grants move the preference, so solo traffic does not skew it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_pf <= 1'b0;
    end else if (grant && sched_elig && pf_elig) begin
      favour_pf <= grant_sched;
    end
  end
`endif

  always_comb begin
    bus.tx_pins = '0;
    case (state)
      HEADER:  bus.tx_pins = NSHIFT'(cmd_q);
      PAYLOAD: bus.tx_pins = owner_sched ? bus.sched_data : bus.pf_data;
      default: bus.tx_pins = '0;
    endcase
  end

  assign bus.sched_cmd_started = sched_started_q;
  assign bus.pf_cmd_started    = pf_started_q;
  assign bus.tx_active         = (state != IDLE);
  assign bus.tx_owner_sched    = owner_sched;
  assign bus.tx_data_next      = (state == PAYLOAD);
  assign bus.tx_counter        = counter_q;
  assign bus.tx_done           = tx_done;
  assign bus.reads_outstanding = reads;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: expected frames are queued when requests are
// driven and checked header-by-header and payload-cycle-by-cycle by a monitor.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NSHIFT         = 2;
  localparam int PAYLOAD_CYCLES = 8;
  localparam int MAX_READS      = 2;

  typedef struct {
    logic        sched;
    tx_cmd_t     cmd;
    logic [1:0]  data;
    int          len;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tx_arbiter_if #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .MAX_READS(MAX_READS)) bus ();

  tx_arbiter #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .MAX_READS(MAX_READS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  frame_t sb[$];
  frame_t cur;
  int     pay_idx = 0;
  bit     in_frame = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit sched, input tx_cmd_t cmd, input logic [1:0] data,
                               input bit reply_wanted);
    frame_t f;
    if (sched) begin
      bus.sched_cmd_valid    = 1'b1;
      bus.sched_cmd          = cmd;
      bus.sched_data         = data;
      bus.sched_reply_wanted = reply_wanted;
    end else begin
      bus.pf_cmd_valid = 1'b1;
      bus.pf_data      = data;
    end
    f.sched = sched;
    f.cmd   = sched ? cmd : CMD_READ_16;
    f.data  = data;
    f.len   = (f.cmd == CMD_WRITE_8) ? PAYLOAD_CYCLES / 2 : PAYLOAD_CYCLES;
    sb.push_back(f);
  endtask

  task automatic waitStart(input bit sched, input bit drop, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sched ? bus.sched_cmd_started : bus.pf_cmd_started) begin
        c = cyc;
        if (drop) begin
          if (sched) bus.sched_cmd_valid = 1'b0;
          else       bus.pf_cmd_valid    = 1'b0;
        end
        break;
      end
    end
    if (c < 0) checkOutput("start_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.tx_active) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic replyPulse();
    @(negedge clk);
    bus.rx_reply_done = 1'b1;
    @(negedge clk);
    bus.rx_reply_done = 1'b0;
  endtask

  // Monitor: pops one expected frame per header and checks every payload cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
    end else if (bus.sched_cmd_started || bus.pf_cmd_started) begin
      checkOutput("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        checkOutput("hdr_pins", bus.tx_pins, cur.cmd);
        checkOutput("hdr_owner", bus.sched_cmd_started, cur.sched);
        checkOutput("hdr_active", bus.tx_active, 1);
        in_frame = 1'b1;
        pay_idx  = 0;
      end
    end else if (in_frame) begin
      checkOutput("pay_next", bus.tx_data_next, 1);
      checkOutput("pay_counter", bus.tx_counter, pay_idx);
      checkOutput("pay_pins", bus.tx_pins, cur.data);
      checkOutput("pay_done", bus.tx_done, pay_idx == cur.len - 1);
      checkOutput("pay_owner", bus.tx_owner_sched, cur.sched);
      pay_idx++;
      if (pay_idx == cur.len) in_frame = 1'b0;
    end
  end

  initial begin
    int n, m, h, h1, h2, h3, hs, hp, ha, hb;
    bit first_sched;
    bus.sched_cmd_valid    = 1'b0;
    bus.sched_cmd          = CMD_READ_16;
    bus.sched_reserve      = 1'b0;
    bus.sched_reply_wanted = 1'b0;
    bus.sched_data         = 2'b00;
    bus.pf_cmd_valid       = 1'b0;
    bus.pf_data            = 2'b00;
    bus.rx_reply_done      = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_active", bus.tx_active, 0);
    checkOutput("rst_pins", bus.tx_pins, 0);
    checkOutput("rst_reads", bus.reads_outstanding, 0);
    checkOutput("rst_owner", bus.tx_owner_sched, 0);
    reset = 1'b0;

    $display("[TB] single scheduler WRITE_16");
    @(negedge clk);
    n = cyc;
    applyStimulus(1'b1, CMD_WRITE_16, 2'b01, 1'b0);
    waitStart(1'b1, 1'b1, h);
    checkOutput("t1_hdr_cyc", h, n + 1);
    waitUntil(n + 9);
    checkOutput("t1_done", bus.tx_done, 1);
    waitUntil(n + 10);
    checkOutput("t1_idle", bus.tx_active, 0);

    $display("[TB] three prefetch reads against the read limit");
    @(negedge clk);
    n = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, CMD_READ_16, 2'b10, 1'b0);
    waitStart(1'b0, 1'b0, h1);
    checkOutput("t2_hdr1_cyc", h1, n + 1);
    checkOutput("t2_reads1", bus.reads_outstanding, 1);
    waitStart(1'b0, 1'b0, h2);
    checkOutput("t2_hdr2_cyc", h2, h1 + 9);
    checkOutput("t2_reads2", bus.reads_outstanding, 2);
    waitUntil(h2 + 14);
    checkOutput("t2_blocked", bus.tx_active, 0);
    checkOutput("t2_reads_held", bus.reads_outstanding, 2);
    @(negedge clk);
    m = cyc;
    bus.rx_reply_done = 1'b1;
    @(negedge clk);
    bus.rx_reply_done = 1'b0;
    checkOutput("t2_freed", bus.reads_outstanding, 1);
    waitStart(1'b0, 1'b1, h3);
    checkOutput("t2_hdr3_cyc", h3, m + 2);
    checkOutput("t2_reads3", bus.reads_outstanding, 2);
    waitIdle();
    replyPulse();
    replyPulse();
    checkOutput("t2_drained", bus.reads_outstanding, 0);

    $display("[TB] simultaneous scheduler WRITE_8 and prefetch read");
    @(negedge clk);
    n = cyc;
    applyStimulus(1'b1, CMD_WRITE_8, 2'b11, 1'b0);
    applyStimulus(1'b0, CMD_READ_16, 2'b01, 1'b0);
    waitStart(1'b1, 1'b1, hs);
    checkOutput("t3_sched_cyc", hs, n + 1);
    waitStart(1'b0, 1'b1, hp);
    checkOutput("t3_pf_cyc", hp, hs + 5);
    waitIdle();
    replyPulse();
`ifdef TX_ARB_ROUND_ROBIN_EN
    first_sched = 1'b0;
`else
    first_sched = 1'b1;
`endif
    @(negedge clk);
    n = cyc;
    if (first_sched) begin
      applyStimulus(1'b1, CMD_WRITE_8, 2'b11, 1'b0);
      applyStimulus(1'b0, CMD_READ_16, 2'b01, 1'b0);
    end else begin
      applyStimulus(1'b0, CMD_READ_16, 2'b01, 1'b0);
      applyStimulus(1'b1, CMD_WRITE_8, 2'b11, 1'b0);
    end
    waitStart(first_sched, 1'b1, ha);
    checkOutput("t3_rep_first_cyc", ha, n + 1);
    waitStart(!first_sched, 1'b1, hb);
    checkOutput("t3_rep_second_cyc", hb, ha + 1 + (first_sched ? 4 : 8));
    waitIdle();
    replyPulse();
    checkOutput("t3_drained", bus.reads_outstanding, 0);

    $display("[TB] reserve blocks prefetch");
    @(negedge clk);
    bus.sched_reserve = 1'b1;
    n = cyc;
    applyStimulus(1'b0, CMD_READ_16, 2'b10, 1'b0);
    waitUntil(n + 5);
    checkOutput("t4_reserved", bus.tx_active, 0);
    bus.sched_reserve = 1'b0;
    m = cyc;
    waitStart(1'b0, 1'b1, h);
    checkOutput("t4_hdr_cyc", h, m + 1);
    waitIdle();

    $display("[TB] uncounted read at limit and same-cycle inc/dec");
    @(negedge clk);
    applyStimulus(1'b0, CMD_READ_16, 2'b01, 1'b0);
    waitStart(1'b0, 1'b1, h);
    waitIdle();
    checkOutput("t5_full", bus.reads_outstanding, 2);
    @(negedge clk);
    n = cyc;
    applyStimulus(1'b1, CMD_READ_16, 2'b00, 1'b0);
    waitStart(1'b1, 1'b1, h);
    checkOutput("t5_uncounted_cyc", h, n + 1);
    checkOutput("t5_uncounted", bus.reads_outstanding, 2);
    waitIdle();
    replyPulse();
    checkOutput("t5_one", bus.reads_outstanding, 1);
    @(negedge clk);
    applyStimulus(1'b1, CMD_READ_16, 2'b10, 1'b1);
    bus.rx_reply_done = 1'b1;
    @(negedge clk);
    bus.rx_reply_done = 1'b0;
    checkOutput("t5_same_start", bus.sched_cmd_started, 1);
    checkOutput("t5_inc_dec", bus.reads_outstanding, 1);
    bus.sched_cmd_valid = 1'b0;
    waitIdle();
    replyPulse();
    checkOutput("t5_drained", bus.reads_outstanding, 0);

    $display("[TB] reset in the middle of a payload");
    @(negedge clk);
    applyStimulus(1'b0, CMD_READ_16, 2'b01, 1'b0);
    waitStart(1'b0, 1'b1, h);
    checkOutput("t6_reads", bus.reads_outstanding, 1);
    waitUntil(h + 4);
    checkOutput("t6_mid_counter", bus.tx_counter, 3);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_pins", bus.tx_pins, 0);
    checkOutput("t6_rst_active", bus.tx_active, 0);
    checkOutput("t6_rst_reads", bus.reads_outstanding, 0);
    checkOutput("t6_rst_counter", bus.tx_counter, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n = cyc;
    applyStimulus(1'b1, CMD_WRITE_8, 2'b10, 1'b0);
    waitStart(1'b1, 1'b1, h);
    checkOutput("t6_restart_cyc", h, n + 1);
    waitIdle();
    checkOutput("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
